// File: rtl/hpdmc_pkg.sv
// Shared constants for the HPDMC management scheduler: SDRAM command
// encodings, scheduler states and request address field positions.
package hpdmc_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;

  localparam int BA_MSB  = 22;
  localparam int BA_LSB  = 21;
  localparam int ROW_MSB = 20;
  localparam int ROW_LSB = 8;
  localparam int COL_MSB = 7;
  localparam int COL_LSB = 0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ACTIVATE,
    ST_WAIT_RCD,
    ST_ISSUE,
    ST_PRECHARGE,
    ST_WAIT_RP,
    ST_PRECHARGE_ALL,
    ST_WAIT_RP_ALL,
    ST_REFRESH,
    ST_WAIT_RFC
  } state_e;

endpackage

// File: rtl/hpdmc_bank_table.sv
// Four-bank open-row table: per-bank open flag and open row, with lookup,
// set, clear-one and clear-all. Clear-all wins over any same-cycle update.
module hpdmc_bank_table (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [1:0]  ba_i,
  input  logic [12:0] row_i,
  input  logic        set_i,
  input  logic        clr_one_i,
  input  logic        clr_all_i,
  output logic        open_o,
  output logic        hit_o,
  output logic        any_open_o
);

  logic [3:0]  open_q;
  logic [12:0] row_q [4];

  assign open_o     = open_q[ba_i];
  assign hit_o      = open_q[ba_i] && (row_q[ba_i] == row_i);
  assign any_open_o = |open_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      open_q <= '0;
      for (int i = 0; i < 4; i++) row_q[i] <= '0;
    end else if (clr_all_i) begin
      open_q <= '0;
    end else begin
      if (clr_one_i) open_q[ba_i] <= 1'b0;
      if (set_i) begin
        open_q[ba_i] <= 1'b1;
        row_q[ba_i]  <= row_i;
      end
    end
  end

endmodule

// File: rtl/hpdmc_mgmt_sched.sv
// SDRAM management scheduler: opens/closes rows, issues READ/WRITE with
// datapath handshakes, and interleaves periodic auto-refresh.
//
// state          | meaning
// ST_IDLE        | pick refresh (priority) or an access request
// ST_ACTIVATE    | issue ACTIVATE for the requested bank/row
// ST_WAIT_RCD    | wait tim_rcd after ACTIVATE
// ST_ISSUE       | issue READ/WRITE once the datapath is safe, ack requester
// ST_PRECHARGE   | close the requested bank (row miss)
// ST_WAIT_RP     | wait tim_rp, then activate
// ST_PRECHARGE_ALL | close all banks before refresh
// ST_WAIT_RP_ALL | wait tim_rp, then refresh
// ST_REFRESH     | issue AUTO REFRESH
// ST_WAIT_RFC    | wait tim_rfc, then idle
module hpdmc_mgmt_sched
  import hpdmc_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        sdram_rst,
  input  logic [2:0]  tim_rp,
  input  logic [2:0]  tim_rcd,
  input  logic [10:0] tim_refi,
  input  logic [3:0]  tim_rfc,
  input  logic        cmd_stb,
  input  logic        cmd_we,
  input  logic [22:0] cmd_adr,
  output logic        cmd_ack,
  input  logic        read_safe,
  input  logic        write_safe,
  input  logic        precharge_safe,
  output logic        read,
  output logic        write,
  output logic        sdram_cs_n,
  output logic        sdram_we_n,
  output logic        sdram_cas_n,
  output logic        sdram_ras_n,
  output logic [12:0] sdram_adr,
  output logic [1:0]  sdram_ba
);

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [10:0] refcnt_q, refcnt_d;
  logic        pending_q, pending_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [12:0] adr_q, adr_d;
  logic [1:0]  ba_q, ba_d;
  logic        ack_q, ack_d;
  logic        read_q, read_d;
  logic        write_q, write_d;

  logic        bt_set, bt_clr_one, bt_clr_all;
  logic        bk_open, bk_hit, any_open;
  logic        ref_issue;
  logic        req_valid;
  logic [1:0]  req_ba;
  logic [12:0] req_row;
  logic [7:0]  req_col;

  assign req_ba  = cmd_adr[BA_MSB:BA_LSB];
  assign req_row = cmd_adr[ROW_MSB:ROW_LSB];
  assign req_col = cmd_adr[COL_MSB:COL_LSB];

  // The ack is registered, so the requester still shows the served request
  // in the cycle it sees the ack; ignore it then to avoid a duplicate.
  assign req_valid = cmd_stb & ~ack_q;

  hpdmc_bank_table u_bank_table (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .ba_i       (req_ba),
    .row_i      (req_row),
    .set_i      (bt_set),
    .clr_one_i  (bt_clr_one),
    .clr_all_i  (bt_clr_all),
    .open_o     (bk_open),
    .hit_o      (bk_hit),
    .any_open_o (any_open)
  );

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    cmd_d      = CMD_NOP;
    adr_d      = adr_q;
    ba_d       = ba_q;
    ack_d      = 1'b0;
    read_d     = 1'b0;
    write_d    = 1'b0;
    bt_set     = 1'b0;
    bt_clr_one = 1'b0;
    bt_clr_all = 1'b0;
    ref_issue  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q)      state_d = any_open ? ST_PRECHARGE_ALL : ST_REFRESH;
        else if (req_valid) state_d = bk_hit ? ST_ISSUE : (bk_open ? ST_PRECHARGE : ST_ACTIVATE);
      end
      ST_ACTIVATE: begin
        cmd_d   = CMD_ACT;
        adr_d   = req_row;
        ba_d    = req_ba;
        bt_set  = 1'b1;
        wait_d  = {1'b0, tim_rcd};
        state_d = ST_WAIT_RCD;
      end
      ST_WAIT_RCD: begin
        if (wait_q == 4'd0) state_d = ST_ISSUE;
        else                wait_d  = wait_q - 4'd1;
      end
      ST_ISSUE: begin
        if (cmd_we ? write_safe : read_safe) begin
          cmd_d   = cmd_we ? CMD_WRITE : CMD_READ;
          adr_d   = {5'b0, req_col};
          ba_d    = req_ba;
          ack_d   = 1'b1;
          read_d  = ~cmd_we;
          write_d = cmd_we;
          state_d = ST_IDLE;
        end
      end
      ST_PRECHARGE: begin
        if (precharge_safe) begin
          cmd_d      = CMD_PRE;
          adr_d      = 13'h0000;
          ba_d       = req_ba;
          bt_clr_one = 1'b1;
          wait_d     = {1'b0, tim_rp};
          state_d    = ST_WAIT_RP;
        end
      end
      ST_WAIT_RP: begin
        if (wait_q == 4'd0) state_d = ST_ACTIVATE;
        else                wait_d  = wait_q - 4'd1;
      end
      ST_PRECHARGE_ALL: begin
        if (precharge_safe) begin
          cmd_d      = CMD_PRE;
          adr_d      = 13'h0400;
          bt_clr_all = 1'b1;
          wait_d     = {1'b0, tim_rp};
          state_d    = ST_WAIT_RP_ALL;
        end
      end
      ST_WAIT_RP_ALL: begin
        if (wait_q == 4'd0) state_d = ST_REFRESH;
        else                wait_d  = wait_q - 4'd1;
      end
      ST_REFRESH: begin
        cmd_d      = CMD_REF;
        bt_clr_all = 1'b1;
        ref_issue  = 1'b1;
        wait_d     = tim_rfc;
        state_d    = ST_WAIT_RFC;
      end
      ST_WAIT_RFC: begin
        if (wait_q == 4'd0) state_d = ST_IDLE;
        else                wait_d  = wait_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (sdram_rst) begin
      state_d    = ST_IDLE;
      cmd_d      = CMD_NOP;
      ack_d      = 1'b0;
      read_d     = 1'b0;
      write_d    = 1'b0;
      bt_set     = 1'b0;
      bt_clr_one = 1'b0;
      bt_clr_all = 1'b1;
      ref_issue  = 1'b0;
    end
  end

  // An expiry coinciding with the refresh being issued is a new interval,
  // so the set takes precedence over the clear.
  always_comb begin
    refcnt_d  = refcnt_q;
    pending_d = pending_q;
    if (sdram_rst) begin
      refcnt_d  = tim_refi;
      pending_d = 1'b0;
    end else begin
      if (ref_issue) pending_d = 1'b0;
      if (refcnt_q == 11'd0) begin
        refcnt_d  = tim_refi;
        pending_d = 1'b1;
      end else begin
        refcnt_d = refcnt_q - 11'd1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      wait_q    <= '0;
      refcnt_q  <= '0;
      pending_q <= 1'b0;
      cmd_q     <= CMD_NOP;
      adr_q     <= '0;
      ba_q      <= '0;
      ack_q     <= 1'b0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      refcnt_q  <= refcnt_d;
      pending_q <= pending_d;
      cmd_q     <= cmd_d;
      adr_q     <= adr_d;
      ba_q      <= ba_d;
      ack_q     <= ack_d;
      read_q    <= read_d;
      write_q   <= write_d;
    end
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_q;
  assign sdram_adr = adr_q;
  assign sdram_ba  = ba_q;
  assign cmd_ack   = ack_q;
  assign read      = read_q;
  assign write     = write_q;

endmodule

// File: tb/tb_hpdmc_mgmt_sched.sv
// Bench for hpdmc_mgmt_sched: directed scenarios plus random traffic, checked
// by a bus-level model of bank state, request contents and command spacing.
module tb_hpdmc_mgmt_sched;

  localparam logic [3:0] C_NOP   = 4'b0111;
  localparam logic [3:0] C_ACT   = 4'b0011;
  localparam logic [3:0] C_READ  = 4'b0101;
  localparam logic [3:0] C_WRITE = 4'b0100;
  localparam logic [3:0] C_PRE   = 4'b0010;
  localparam logic [3:0] C_REF   = 4'b0001;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        sdram_rst = 1'b0;
  logic [2:0]  tim_rp = 3'd2;
  logic [2:0]  tim_rcd = 3'd2;
  logic [10:0] tim_refi = 11'd2047;
  logic [3:0]  tim_rfc = 4'd3;
  logic        cmd_stb = 1'b0;
  logic        cmd_we = 1'b0;
  logic [22:0] cmd_adr = '0;
  logic        cmd_ack;
  logic        read_safe = 1'b1;
  logic        write_safe = 1'b1;
  logic        precharge_safe = 1'b1;
  logic        read, write;
  logic        sdram_cs_n, sdram_we_n, sdram_cas_n, sdram_ras_n;
  logic [12:0] sdram_adr;
  logic [1:0]  sdram_ba;

  always #5 sys_clk = ~sys_clk;

  hpdmc_mgmt_sched dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .sdram_rst      (sdram_rst),
    .tim_rp         (tim_rp),
    .tim_rcd        (tim_rcd),
    .tim_refi       (tim_refi),
    .tim_rfc        (tim_rfc),
    .cmd_stb        (cmd_stb),
    .cmd_we         (cmd_we),
    .cmd_adr        (cmd_adr),
    .cmd_ack        (cmd_ack),
    .read_safe      (read_safe),
    .write_safe     (write_safe),
    .precharge_safe (precharge_safe),
    .read           (read),
    .write          (write),
    .sdram_cs_n     (sdram_cs_n),
    .sdram_we_n     (sdram_we_n),
    .sdram_cas_n    (sdram_cas_n),
    .sdram_ras_n    (sdram_ras_n),
    .sdram_adr      (sdram_adr),
    .sdram_ba       (sdram_ba)
  );

  typedef struct {
    int          cyc;
    logic [3:0]  cmd;
    logic [12:0] adr;
    logic [1:0]  ba;
  } ev_t;

  ev_t         log_q[$];
  int          n_checks = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          last_cyc = -1000;
  int          min_gap = 0;
  int          ref_count = 0;
  logic        bopen [4];
  logic [12:0] brow [4];

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_ge(input int obs, input int req, input string tag);
    n_checks++;
    assert (obs >= req) else begin
      n_err++;
      $error("FAIL %s: observed=%0d required>=%0d", tag, obs, req);
    end
  endtask

  // One clock; inputs were set before the edge, outputs examined at the
  // following negedge against the bus-level model.
  task automatic tick();
    logic       ps, rs, ws, sr, rw;
    logic [3:0] obs;
    logic [1:0] rba;
    logic [12:0] rrow;
    ps = precharge_safe; rs = read_safe; ws = write_safe; sr = sdram_rst;
    @(posedge sys_clk);
    @(negedge sys_clk);
    cyc++;
    obs  = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
    rba  = cmd_adr[22:21];
    rrow = cmd_adr[20:8];
    rw   = (obs == C_READ) || (obs == C_WRITE);
    if (obs != C_NOP) log_q.push_back('{cyc, obs, sdram_adr, sdram_ba});
    check({cmd_ack, read, write}, rw ? {1'b1, ~cmd_we, cmd_we} : 3'b000, "strobes");
    if (sr) begin
      check(obs, C_NOP, "sdram_rst_nop");
      for (int i = 0; i < 4; i++) bopen[i] = 1'b0;
      last_cyc = -1000;
      min_gap  = 0;
    end else if (obs != C_NOP) begin
      check_ge(cyc - last_cyc, min_gap, "cmd_gap");
      last_cyc = cyc;
      case (obs)
        C_ACT: begin
          check(cmd_stb, 1'b1, "act_req");
          check(sdram_adr, rrow, "act_row");
          check(sdram_ba, rba, "act_ba");
          check(bopen[sdram_ba], 1'b0, "act_bank_closed");
          bopen[sdram_ba] = 1'b1;
          brow[sdram_ba]  = sdram_adr;
          min_gap = int'(tim_rcd) + 1;
        end
        C_READ, C_WRITE: begin
          check(cmd_stb, 1'b1, "rw_req");
          check(obs, cmd_we ? C_WRITE : C_READ, "rw_dir");
          check(sdram_adr, {5'b0, cmd_adr[7:0]}, "rw_col");
          check(sdram_ba, rba, "rw_ba");
          check(bopen[rba] && brow[rba] == rrow, 1'b1, "rw_row_open");
          check(cmd_we ? ws : rs, 1'b1, "rw_safe");
          min_gap = 1;
        end
        C_PRE: begin
          check(ps, 1'b1, "pre_safe");
          if (sdram_adr[10]) begin
            for (int i = 0; i < 4; i++) bopen[i] = 1'b0;
          end else begin
            check(sdram_ba, rba, "pre_ba");
            check(bopen[rba] && brow[rba] != rrow, 1'b1, "pre_row_miss");
            bopen[sdram_ba] = 1'b0;
          end
          min_gap = int'(tim_rp) + 1;
        end
        C_REF: begin
          check({bopen[0], bopen[1], bopen[2], bopen[3]}, 4'b0000, "ref_all_closed");
          ref_count++;
          min_gap = int'(tim_rfc) + 1;
        end
        default: check(obs, C_NOP, "illegal_cmd");
      endcase
    end
  endtask

  task automatic do_access(input logic we, input logic [22:0] adr, input int bound,
                           input bit rnd, output int lat);
    bit got;
    got = 0;
    lat = 0;
    cmd_we  = we;
    cmd_adr = adr;
    cmd_stb = 1'b1;
    while (!got && lat < bound) begin
      if (rnd) begin
        read_safe      = ($urandom_range(0, 3) != 0);
        write_safe     = ($urandom_range(0, 3) != 0);
        precharge_safe = ($urandom_range(0, 3) != 0);
      end
      tick();
      lat++;
      if (cmd_ack === 1'b1) got = 1;
    end
    cmd_stb = 1'b0;
    check(got, 1'b1, "ack_within_bound");
  endtask

  initial begin
    int lat, n, ri;
    for (int i = 0; i < 4; i++) begin bopen[i] = 1'b0; brow[i] = '0; end

    // reset values
    repeat (3) @(negedge sys_clk);
    check({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, C_NOP, "rst_cmd");
    check(sdram_adr, 13'h0, "rst_adr");
    check(sdram_ba, 2'h0, "rst_ba");
    check({cmd_ack, read, write}, 3'b000, "rst_strobes");
    sys_rst_n = 1'b1;
    tick();
    check(log_q.size(), 0, "first_cycle_nop");
    n = 0;
    while (log_q.size() == 0 && n < 10) begin tick(); n++; end
    check(log_q.size() > 0, 1'b1, "boot_refresh_seen");
    if (log_q.size() > 0) check(log_q[0].cmd, C_REF, "boot_refresh_cmd");
    repeat (8) tick();

    // closed bank read: ACTIVATE then READ
    log_q.delete();
    do_access(1'b0, 23'h000105, 40, 1'b0, lat);
    check(log_q.size(), 2, "idle_read_count");
    if (log_q.size() == 2) begin
      check(log_q[0].cmd, C_ACT, "idle_read_act");
      check(log_q[0].adr, 13'd1, "idle_read_row");
      check(log_q[0].ba, 2'd0, "idle_read_ba");
      check(log_q[1].cmd, C_READ, "idle_read_cmd");
      check(log_q[1].adr, 13'h005, "idle_read_col");
      check_ge(log_q[1].cyc - log_q[0].cyc, 3, "idle_read_rcd");
    end

    // row hit: READ on the cycle after ISSUE is entered
    tick();
    log_q.delete();
    do_access(1'b0, 23'h000107, 40, 1'b0, lat);
    check(log_q.size(), 1, "hit_count");
    if (log_q.size() == 1) check(log_q[0].cmd, C_READ, "hit_cmd");
    check(lat, 2, "hit_latency");

    // row miss: PRECHARGE, ACTIVATE, WRITE
    tick();
    log_q.delete();
    do_access(1'b1, 23'h000209, 40, 1'b0, lat);
    check(log_q.size(), 3, "miss_count");
    if (log_q.size() == 3) begin
      check(log_q[0].cmd, C_PRE, "miss_pre");
      check(log_q[0].adr[10], 1'b0, "miss_pre_a10");
      check(log_q[1].cmd, C_ACT, "miss_act");
      check(log_q[1].adr, 13'd2, "miss_act_row");
      check(log_q[2].cmd, C_WRITE, "miss_write");
      check_ge(log_q[1].cyc - log_q[0].cyc, 3, "miss_rp_gap");
      check_ge(log_q[2].cyc - log_q[1].cyc, 3, "miss_rcd_gap");
    end

    // write stalled by write_safe in ISSUE
    tick();
    log_q.delete();
    write_safe = 1'b0;
    cmd_we = 1'b1; cmd_adr = 23'h000209; cmd_stb = 1'b1;
    repeat (6) tick();
    check(log_q.size(), 0, "stall_no_cmd");
    write_safe = 1'b1;
    tick();
    check(log_q.size(), 1, "stall_release_count");
    if (log_q.size() == 1) check(log_q[0].cmd, C_WRITE, "stall_release_write");
    check(cmd_ack, 1'b1, "stall_release_ack");
    cmd_stb = 1'b0;
    tick();

    // refresh with an open bank: PRECHARGE ALL, AUTO REFRESH, then access
    tim_refi = 11'd10;
    sdram_rst = 1'b1;
    tick();
    sdram_rst = 1'b0;
    do_access(1'b0, 23'h000209, 40, 1'b0, lat);
    log_q.delete();
    n = 0;
    while (log_q.size() == 0 && n < 60) begin tick(); n++; end
    check(log_q.size() > 0, 1'b1, "refi_prea_seen");
    if (log_q.size() > 0) begin
      check(log_q[0].cmd, C_PRE, "refi_prea_cmd");
      check(log_q[0].adr[10], 1'b1, "refi_prea_a10");
    end
    do_access(1'b0, 23'h000209, 80, 1'b0, lat);
    ri = -1;
    for (int i = 0; i < log_q.size(); i++) if (ri < 0 && log_q[i].cmd == C_REF) ri = i;
    check(ri, 1, "refi_ref_index");
    if (ri == 1) begin
      check_ge(log_q[1].cyc - log_q[0].cyc, int'(tim_rp) + 1, "refi_rp_gap");
      check(log_q[log_q.size() - 1].cmd, C_READ, "refi_final_read");
      check_ge(log_q[log_q.size() - 1].cyc - log_q[1].cyc, int'(tim_rfc) + 1, "refi_rfc_gap");
    end
    tim_refi = 11'd2047;
    sdram_rst = 1'b1;
    tick();
    sdram_rst = 1'b0;
    tick();

    // sdram_rst during WAIT_RCD abandons the access and closes the bank
    log_q.delete();
    cmd_we = 1'b0; cmd_adr = 23'h400503; cmd_stb = 1'b1;
    n = 0;
    while (log_q.size() == 0 && n < 10) begin tick(); n++; end
    check(log_q.size(), 1, "abort_act_seen");
    if (log_q.size() == 1) check(log_q[0].cmd, C_ACT, "abort_act_cmd");
    sdram_rst = 1'b1;
    tick();
    check({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, C_NOP, "abort_nop");
    sdram_rst = 1'b0;
    cmd_stb = 1'b0;
    repeat (6) tick();
    check(log_q.size(), 1, "abort_quiet");
    log_q.delete();
    do_access(1'b0, 23'h400503, 40, 1'b0, lat);
    check(log_q.size(), 2, "abort_reaccess_count");
    if (log_q.size() == 2) begin
      check(log_q[0].cmd, C_ACT, "abort_reactivate");
      check(log_q[0].adr, 13'd5, "abort_reactivate_row");
    end

    // random traffic under random timing and datapath back-pressure
    tim_rp   = 3'($urandom_range(0, 7));
    tim_rcd  = 3'($urandom_range(0, 7));
    tim_rfc  = 4'($urandom_range(0, 15));
    tim_refi = 11'($urandom_range(30, 80));
    sdram_rst = 1'b1;
    tick();
    sdram_rst = 1'b0;
    ref_count = 0;
    for (int k = 0; k < 150; k++) begin
      logic [22:0] a;
      a = {2'($urandom_range(0, 3)), 13'($urandom_range(0, 3)), 8'($urandom_range(0, 255))};
      do_access(1'($urandom_range(0, 1)), a, 300, 1'b1, lat);
      if ($urandom_range(0, 2) == 0) tick();
    end
    read_safe = 1'b1; write_safe = 1'b1; precharge_safe = 1'b1;
    repeat (5) tick();
    check(ref_count > 0, 1'b1, "rand_refresh_seen");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/hpdmc_mgmt_sched.md
HPDMC_MGMT_SCHED -- requirements
Module: hpdmc_mgmt_sched

Interface
REQ-001 SHALL have ports, clock and reset first; reset asynchronous, active-low:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- sdram_rst  in  1  synchronous hold: FSM idle, banks closed, NOPs only
- tim_rp  in  3  wait after PRECHARGE
- tim_rcd  in  3  wait after ACTIVATE
- tim_refi  in  11  refresh interval
- tim_rfc  in  4  wait after AUTO REFRESH
- cmd_stb  in  1  access request valid
- cmd_we  in  1  1=write, 0=read
- cmd_adr  in  23  ba=[22:21], row=[20:8], col=[7:0]
- cmd_ack  out  1  one-cycle accept pulse
- read_safe, write_safe, precharge_safe  in  1 each  datapath permits
- read, write  out  1 each  one-cycle pulse to datapath with command
- sdram_cs_n, sdram_we_n, sdram_cas_n, sdram_ras_n  out  1 each  registered command
- sdram_adr  out  13  registered address
- sdram_ba  out  2  registered bank
REQ-002 SHALL use a single clock, sys_clk; reset asynchronous, active-low, sys_rst_n.

Function
REQ-003 SHALL encode (cs,ras,cas,we)_n: NOP 0111, ACTIVATE 0011, READ 0101, WRITE 0100, PRECHARGE 0010, AUTO REFRESH 0001; NOP on every cycle no command issues.
REQ-004 SHALL track 4 banks: open flag plus 13-bit open row each.
REQ-005 SHALL implement FSM states IDLE, ACTIVATE, WAIT_RCD, ISSUE, PRECHARGE, WAIT_RP, PRECHARGE_ALL, WAIT_RP_ALL, REFRESH, WAIT_RFC.
REQ-006 SHALL, when a command issues at cycle N, issue its dependent command no earlier than cycle N+tim+1 (tim = tim_rp/tim_rcd/tim_rfc as applicable); the down-counter loads tim at N.
REQ-007 SHALL, in IDLE with cmd_stb and no refresh pending: row hit -> ISSUE; bank closed -> ACTIVATE; bank open on other row -> PRECHARGE.
REQ-008 SHALL issue ACTIVATE with sdram_adr=row, sdram_ba=ba, then set bank open/row.
REQ-009 SHALL issue single-bank PRECHARGE (A10=0) only when precharge_safe=1, then clear that bank's open flag.
REQ-010 SHALL in ISSUE drive READ/WRITE only when read_safe/write_safe=1: sdram_adr={5'b0,col}, A10=0; same cycle cmd_ack=1 and read or write=1; return to IDLE next cycle.
REQ-011 SHALL keep a refresh down-counter: reset value 0, decrements each cycle, reloads tim_refi at zero and sets refresh_pending; further expiries while pending are not counted.
REQ-012 SHALL service refresh_pending from IDLE: any bank open -> PRECHARGE_ALL (A10=1, needs precharge_safe), wait tim_rp, then REFRESH; none open -> REFRESH directly; REFRESH clears pending and all open flags; wait tim_rfc, then IDLE.
REQ-013 SHALL give refresh priority over cmd_stb in IDLE; an access already past IDLE completes first.
REQ-014 SHALL, while sdram_rst=1, force IDLE, clear open flags and pending, hold refresh counter at tim_refi, output NOP, keep cmd_ack/read/write low; applies mid-operation, abandoning it.
REQ-015 SHALL not acknowledge a request except via ISSUE; cmd_adr/cmd_we are held stable by requester until cmd_ack.

Reset
REQ-016 SHALL, on sys_rst_n low: state IDLE, all open flags 0, refresh counter 0, pending 0, wait counter 0, command NOP, sdram_adr 0, sdram_ba 0, cmd_ack/read/write 0.
REQ-017 SHALL exit reset synchronously to sys_clk with no command in the first cycle.

Structure
REQ-018 SHALL place command encodings, FSM state constants and address-field offsets in shared package hpdmc_pkg.
REQ-019 SHALL implement the 4-bank open-row table as sub-module hpdmc_bank_table (lookup hit/open, set, clear-one, clear-all).

Verification
REQ-020 Idle read, bank 0 closed, tim_rcd=2: cmd_adr=0x000105 -> ACTIVATE row 1 at N, READ col 0x05 no earlier than N+3, cmd_ack and read pulsed there.
REQ-021 Row hit: second read same row after REQ-020 -> READ the cycle after ISSUE is entered, no ACTIVATE.
REQ-022 Row miss bank 0 row 1 open, request row 2, tim_rp=2, tim_rcd=2 -> PRECHARGE, ACTIVATE >=3 later, WRITE >=3 later.
REQ-023 tim_refi=10, bank open, cmd_stb held -> PRECHARGE_ALL with A10=1, AUTO REFRESH after tim_rp+1, request served only after tim_rfc+1 cycles.
REQ-024 write_safe=0 for 5 cycles during ISSUE -> NOP until write_safe=1, then WRITE+cmd_ack in that cycle.
REQ-025 sdram_rst asserted in WAIT_RCD -> NOP next cycle, IDLE, bank closed; later access re-ACTIVATEs.
